uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter with a small transmit FIFO.
// Characters written through wr_data/wr_valid are queued and shifted out
// LSB first with a start bit, optional even/odd parity and 1 or 2 stop bits.
module uart_tx_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [1:0]           parity_mode,
   output logic                 tx,
   output logic                 busy,
   output logic [CW-1:0]        fifo_count
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam int BCW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int PW         = $clog2(FIFO_DEPTH);

   localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_CYCLES - 1);
   localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);
   localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state, next_state;

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, count_next;
   logic                 push, pop, fifo_empty;

   logic [BCW-1:0]       bit_cnt;
   logic [3:0]           bit_idx;
   logic                 bit_done, data_last, stop_last;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_en;
   logic                 tx_next, shift_en;

   assign fifo_empty = (count == '0);
   assign wr_ready   = (count != FULL_COUNT);
   assign push       = wr_valid && wr_ready;
   assign fifo_count = count;

   assign bit_done   = (bit_cnt == BIT_LAST);
   assign data_last  = (bit_idx == DATA_LAST);
   assign stop_last  = (bit_idx == STOP_LAST);

   // Occupancy after this edge: a simultaneous push and pop cancel out
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage array has no reset; only the pointers and count define validity
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state: every line bit ends when the bit counter reaches its last cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (!fifo_empty) next_state = START;
         START:  if (bit_done) next_state = DATA;
         DATA:   if (bit_done && data_last) next_state = par_en ? PARITY : STOP;
         PARITY: if (bit_done) next_state = STOP;
         STOP:   if (bit_done && stop_last) next_state = fifo_empty ? IDLE : START;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs: next line level, FIFO pop and shift-register advance
   always_comb begin
      pop      = 1'b0;
      shift_en = 1'b0;
      tx_next  = tx;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               tx_next = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               tx_next  = shreg[0];
               shift_en = 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (!data_last) begin
                  tx_next  = shreg[0];
                  shift_en = 1'b1;
               end else begin
                  tx_next = par_en ? par_bit : 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_done) tx_next = 1'b1;
         end
         STOP: begin
            if (bit_done && stop_last) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  tx_next = 1'b0;
               end else begin
                  tx_next = 1'b1;
               end
            end
         end
         default: tx_next = 1'b1;
      endcase
   end

   // Datapath: registered line, bit timing, frame latch of data and parity mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx      <= 1'b1;
         busy    <= 1'b0;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         par_en  <= 1'b0;
      end else begin
         tx   <= tx_next;
         busy <= (next_state != IDLE) || (count_next != '0);
         if (state == IDLE || bit_done) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + BCW'(1);
         end
         if (next_state != state) begin
            bit_idx <= '0;
         end else if (bit_done) begin
            bit_idx <= bit_idx + 4'd1;
         end
         if (pop) begin
            shreg   <= fifo_mem[rd_ptr];
            par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit <= (^fifo_mem[rd_ptr]) ^ (parity_mode == 2'b10);
         end else if (shift_en) begin
            shreg <= shreg >> 1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg. Expected line waveforms
// are built from frame rules (start, LSB-first data, parity, stop) and compared
// bit by bit against the sampled tx line. A second instance covers 7N2 framing.
module tb_uart_tx_cfg;

   localparam int CLK_FREQ  = 1_000_000;
   localparam int BAUD_RATE = 100_000;
   localparam int BC        = 10;
   localparam int DEPTH     = 4;
   localparam int CW        = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [1:0]    parity_mode = 2'b00;
   logic          tx, busy;
   logic [CW-1:0] fifo_count;

   logic [6:0]    wr_data7 = '0;
   logic          wr_valid7 = 1'b0;
   logic          wr_ready7, tx7, busy7;
   logic [CW-1:0] fifo_count7;

   int checks = 0;
   int passed = 0;

   logic       line_q[$];
   int         cnt_q[$];
   logic       busy_q[$];
   logic       ready_q[$];
   logic       exp_q[$];
   bit         wv_q[$];
   logic [7:0] wd_q[$];
   logic [1:0] wm_q[$];

   always #5 clk = ~clk;

   uart_tx_cfg #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
      .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .parity_mode(parity_mode), .tx(tx),
      .busy(busy), .fifo_count(fifo_count)
   );

   uart_tx_cfg #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
      .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
   ) u_dut7 (
      .clk(clk), .rst(rst), .wr_data(wr_data7), .wr_valid(wr_valid7),
      .wr_ready(wr_ready7), .parity_mode(parity_mode), .tx(tx7),
      .busy(busy7), .fifo_count(fifo_count7)
   );

   // Reference model: append one frame's line bits (one entry per bit period)
   function automatic void add_frame(input logic [7:0] data, input logic [1:0] mode,
                                     input int dbits, input int sbits);
      int ones;
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < dbits; i++) begin
         exp_q.push_back(data[i]);
         ones += int'(data[i]);
      end
      if (mode == 2'b01) exp_q.push_back((ones % 2) == 1);
      else if (mode == 2'b10) exp_q.push_back((ones % 2) == 0);
      for (int i = 0; i < sbits; i++) exp_q.push_back(1'b1);
   endfunction

   function automatic void queue_write(input bit v, input logic [7:0] d, input logic [1:0] m);
      wv_q.push_back(v);
      wd_q.push_back(d);
      wm_q.push_back(m);
   endfunction

   // Drive queued write cycles and record the line once per cycle at the falling edge
   task automatic capture(input int n, input bit sel);
      bit         v;
      logic [7:0] d;
      line_q.delete(); cnt_q.delete(); busy_q.delete(); ready_q.delete();
      for (int i = 0; i < n; i++) begin
         if (wv_q.size() > 0) begin
            v = wv_q.pop_front();
            d = wd_q.pop_front();
            parity_mode = wm_q.pop_front();
            if (sel) begin wr_valid7 = v; wr_data7 = d[6:0]; end
            else begin wr_valid = v; wr_data = d; end
         end else begin
            wr_valid  = 1'b0;
            wr_valid7 = 1'b0;
         end
         @(negedge clk);
         if (sel) begin
            line_q.push_back(tx7); cnt_q.push_back(int'(fifo_count7));
            busy_q.push_back(busy7); ready_q.push_back(wr_ready7);
         end else begin
            line_q.push_back(tx); cnt_q.push_back(int'(fifo_count));
            busy_q.push_back(busy); ready_q.push_back(wr_ready);
         end
      end
      wr_valid  = 1'b0;
      wr_valid7 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b want 1", tx); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", fifo_count); else passed++;
      checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", wr_ready); else passed++;
      checks++; if (tx7 !== 1'b1) $display("[TB] FAIL reset_tx7: got %b want 1", tx7); else passed++;
      checks++; if (busy7 !== 1'b0) $display("[TB] FAIL reset_busy7: got %b want 0", busy7); else passed++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) $display("[TB] FAIL idle_tx: got %b want 1", tx); else passed++;
   endtask

   task automatic test_single;
      logic got; bit bad;
      exp_q.delete();
      add_frame(8'h55, 2'b00, 8, 1);
      exp_q.push_back(1'b1);
      queue_write(1'b1, 8'h55, 2'b00);
      capture(1 + exp_q.size() * BC, 1'b0);
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 1'b0; got = exp_q[b];
         for (int c = 0; c < BC; c++)
            if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
         checks++;
         if (bad) $display("[TB] FAIL single_bit%0d: tx %b want %b", b, got, exp_q[b]); else passed++;
      end
      checks++; if (busy_q[1] !== 1'b1) $display("[TB] FAIL single_busy_start: got %b want 1", busy_q[1]); else passed++;
      checks++; if (busy_q[100] !== 1'b1) $display("[TB] FAIL single_busy_last: got %b want 1", busy_q[100]); else passed++;
      checks++; if (busy_q[101] !== 1'b0) $display("[TB] FAIL single_busy_end: got %b want 0", busy_q[101]); else passed++;
   endtask

   task automatic test_parity;
      logic got; bit bad;
      exp_q.delete();
      add_frame(8'h07, 2'b01, 8, 1);
      add_frame(8'h07, 2'b10, 8, 1);
      exp_q.push_back(1'b1);
      queue_write(1'b1, 8'h07, 2'b01);
      queue_write(1'b0, 8'h00, 2'b01);
      queue_write(1'b1, 8'h07, 2'b10);
      capture(1 + exp_q.size() * BC, 1'b0);
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 1'b0; got = exp_q[b];
         for (int c = 0; c < BC; c++)
            if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
         checks++;
         if (bad) $display("[TB] FAIL parity_bit%0d: tx %b want %b", b, got, exp_q[b]); else passed++;
      end
      checks++; if (line_q[96] !== 1'b1) $display("[TB] FAIL parity_even: got %b want 1", line_q[96]); else passed++;
      checks++; if (line_q[206] !== 1'b0) $display("[TB] FAIL parity_odd: got %b want 0", line_q[206]); else passed++;
      checks++; if (busy_q[220] !== 1'b1) $display("[TB] FAIL parity_busy_last: got %b want 1", busy_q[220]); else passed++;
      checks++; if (busy_q[221] !== 1'b0) $display("[TB] FAIL parity_busy_end: got %b want 0", busy_q[221]); else passed++;
   endtask

   task automatic test_back_to_back;
      logic got; bit bad; int peak;
      exp_q.delete();
      add_frame(8'hA1, 2'b00, 8, 1);
      add_frame(8'hB2, 2'b00, 8, 1);
      add_frame(8'hC3, 2'b00, 8, 1);
      exp_q.push_back(1'b1);
      queue_write(1'b1, 8'hA1, 2'b00);
      queue_write(1'b1, 8'hB2, 2'b00);
      queue_write(1'b1, 8'hC3, 2'b00);
      capture(1 + exp_q.size() * BC, 1'b0);
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 1'b0; got = exp_q[b];
         for (int c = 0; c < BC; c++)
            if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
         checks++;
         if (bad) $display("[TB] FAIL b2b_bit%0d: tx %b want %b", b, got, exp_q[b]); else passed++;
      end
      peak = 0;
      foreach (cnt_q[i]) if (cnt_q[i] > peak) peak = cnt_q[i];
      checks++; if (peak != 2) $display("[TB] FAIL b2b_peak_count: got %0d want 2", peak); else passed++;
   endtask

   task automatic test_fifo_full;
      logic got; bit bad;
      exp_q.delete();
      for (int i = 0; i < 5; i++) add_frame(8'h10 + 8'(i * 17), 2'b00, 8, 1);
      exp_q.push_back(1'b1);
      for (int i = 0; i < 6; i++) queue_write(1'b1, 8'h10 + 8'(i * 17), 2'b00);
      capture(1 + exp_q.size() * BC + 2 * BC, 1'b0);
      checks++; if (cnt_q[4] != 4) $display("[TB] FAIL full_count: got %0d want 4", cnt_q[4]); else passed++;
      checks++; if (ready_q[4] !== 1'b0) $display("[TB] FAIL full_ready: got %b want 0", ready_q[4]); else passed++;
      checks++; if (cnt_q[5] != 4) $display("[TB] FAIL full_write_ignored: got %0d want 4", cnt_q[5]); else passed++;
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 1'b0; got = exp_q[b];
         for (int c = 0; c < BC; c++)
            if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
         checks++;
         if (bad) $display("[TB] FAIL full_bit%0d: tx %b want %b", b, got, exp_q[b]); else passed++;
      end
      checks++;
      if (busy_q[busy_q.size()-1] !== 1'b0) $display("[TB] FAIL full_busy_end: got %b want 0", busy_q[busy_q.size()-1]);
      else passed++;
   endtask

   task automatic test_random;
      logic got; bit bad; int n, peak, want_peak;
      logic [1:0] mode; logic [7:0] d; int errs;
      for (int it = 0; it < 4; it++) begin
         n    = int'($urandom_range(1, 5));
         mode = 2'($urandom_range(0, 3));
         exp_q.delete();
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            add_frame(d, mode, 8, 1);
            queue_write(1'b1, d, mode);
         end
         exp_q.push_back(1'b1);
         capture(1 + exp_q.size() * BC, 1'b0);
         errs = 0;
         for (int b = 0; b < exp_q.size(); b++) begin
            bad = 1'b0; got = exp_q[b];
            for (int c = 0; c < BC; c++)
               if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
            if (bad) begin
               errs++;
               $display("[TB] FAIL random%0d_bit%0d: tx %b want %b", it, b, got, exp_q[b]);
            end
         end
         checks++; if (errs == 0) passed++;
         peak = 0;
         foreach (cnt_q[i]) if (cnt_q[i] > peak) peak = cnt_q[i];
         want_peak = (n > 1) ? n - 1 : 1;
         checks++;
         if (peak != want_peak) $display("[TB] FAIL random%0d_peak: got %0d want %0d", it, peak, want_peak);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_frame;
      bit bad;
      queue_write(1'b1, 8'hFF, 2'b00);
      queue_write(1'b1, 8'h11, 2'b00);
      queue_write(1'b1, 8'h22, 2'b00);
      capture(46, 1'b0);
      checks++; if (cnt_q[45] != 2) $display("[TB] FAIL midrst_queued: got %0d want 2", cnt_q[45]); else passed++;
      #1 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) $display("[TB] FAIL midrst_tx: got %b want 1", tx); else passed++;
      checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL midrst_count: got %0d want 0", fifo_count); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passed++;
      checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL midrst_ready: got %b want 1", wr_ready); else passed++;
      @(negedge clk);
      rst = 1'b0;
      capture(200, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 200; i++) if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b0 || cnt_q[i] != 0) bad = 1'b1;
      checks++; if (bad) $display("[TB] FAIL midrst_no_resume: line or busy active with no new write"); else passed++;
      queue_write(1'b1, 8'h3C, 2'b00);
      capture(6, 1'b0);
      checks++; if (line_q[5] !== 1'b0) $display("[TB] FAIL restart_start_bit: got %b want 0", line_q[5]); else passed++;
      #1 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) $display("[TB] FAIL startrst_tx: got %b want 1", tx); else passed++;
      @(negedge clk);
      rst = 1'b0;
      capture(30, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 30; i++) if (line_q[i] !== 1'b1) bad = 1'b1;
      checks++; if (bad) $display("[TB] FAIL startrst_no_partial: line left idle level"); else passed++;
   endtask

   task automatic test_7n2;
      logic got; bit bad;
      exp_q.delete();
      add_frame(8'h55, 2'b00, 7, 2);
      exp_q.push_back(1'b1);
      queue_write(1'b1, 8'h55, 2'b00);
      capture(1 + exp_q.size() * BC, 1'b1);
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 1'b0; got = exp_q[b];
         for (int c = 0; c < BC; c++)
            if (line_q[1 + b*BC + c] !== exp_q[b]) begin bad = 1'b1; got = line_q[1 + b*BC + c]; end
         checks++;
         if (bad) $display("[TB] FAIL n72_bit%0d: tx %b want %b", b, got, exp_q[b]); else passed++;
      end
      checks++; if (busy_q[100] !== 1'b1) $display("[TB] FAIL n72_busy_last: got %b want 1", busy_q[100]); else passed++;
      checks++; if (busy_q[101] !== 1'b0) $display("[TB] FAIL n72_busy_end: got %b want 0", busy_q[101]); else passed++;
   endtask

   // Scenario sequence; every step has a fixed cycle length so the run always ends
   initial begin
      $display("[TB] uart_tx_cfg bench start");
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_fifo_full();
      test_random();
      test_reset_mid_frame();
      test_7n2();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
